dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- MEM-stage load/store controller; the initiating side of the data-memory interface.
- Converts a pipeline load/store into a ready-handshaked, word-only memory transaction and stalls the pipeline until the transaction completes.
- Sign- or zero-extends byte/halfword loads.
- Implements byte/halfword stores as read-modify-write, because the memory has no byte enables.

Parameters:
- MEM_WORDS, 256: memory depth in 32-bit words. Word-address width AW = clog2(MEM_WORDS).

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  asynchronous active-low reset
- req_i  input  1  MEM stage holds a valid load/store; held stable while stall_o=1
- MemRead_i  input  1  load
- MemWrite_i  input  1  store; wins if MemRead_i is also high
- size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- unsigned_i  input  1  loads: zero-extend (1) or sign-extend (0)
- Address_i  input  32  byte address
- Writedata_i  input  32  store data, right-aligned
- Readdata_o  output  32  extended load result
- stall_o  output  1  freeze IF/ID/EX/MEM
- misalign_o  output  1  one-cycle pulse on a misaligned access (see optional feature)
- mem_addr_o  output  AW  word address = Address_i[AW+1:2]; upper bits are dropped (wraps modulo MEM_WORDS)
- mem_read_o  output  1  read strobe
- mem_write_o  output  1  write strobe
- mem_wdata_o  output  32  write data
- mem_rdata_i  input  32  read data, valid when mem_ready_i=1
- mem_ready_i  input  1  completes the current strobe

Behaviour:
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- Reset (asynchronous, rst_n_i low):
  - state=IDLE.
  - Readdata_o=0, mem_read_o=0, mem_write_o=0, mem_wdata_o=0, mem_addr_o=0, misalign_o=0.
  - stall_o forced 0 while reset is asserted.
- Reset mid-transaction: strobes drop immediately, with no write completion. The pipeline re-presents the request after reset.
- IDLE with req_i=1 and (MemRead_i|MemWrite_i):
  - Latch address, size, unsigned flag and data.
  - Next state: word store -> WR; sub-word store -> RMW_RD; load -> RD.
  - req_i with neither read nor write: ignored, no stall.
- RD, WR, RMW_RD, RMW_WR each assert the matching strobe and hold mem_addr_o/mem_wdata_o stable until mem_ready_i=1 is sampled. Any number of wait cycles is allowed.
- RD exit: capture mem_rdata_i, select the byte lane from addr[1:0] or the half lane from addr[1], extend, register into Readdata_o, go to DONE.
- RMW_RD exit: merge the store data into the selected lane of mem_rdata_i, drive the merged word on mem_wdata_o, go to RMW_WR.
- WR and RMW_WR exit: go to DONE.
- DONE:
  - stall_o=0, Readdata_o valid this cycle and held until the next load completes.
  - Unconditionally go to IDLE. The pipeline advances on this edge, so a request is never issued twice.
- stall_o = req_i & (MemRead_i|MemWrite_i) & (state != DONE).
- Latency with zero-wait memory (ready in the first strobe cycle):
  - load/word store: stall 2 cycles, complete in cycle 3.
  - sub-word store: stall 3 cycles.
  - Each memory wait cycle adds 1.
- Strobes are never high together; at most one strobe cycle per ready.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is detected in IDLE.
  - misalign_o pulses for 1 cycle and the state goes straight to DONE with no memory strobe.
  - Load returns Readdata_o=0; store is dropped. Stall is 1 cycle.
- Undefined: misalign_o is tied 0, and the low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0) before the access.

Test Plan:
- lw, Address_i=0x10, memory word 4 = 0xDEADBEEF, ready always high -> mem_read_o high 1 cycle at mem_addr_o=4, stall_o high 2 cycles, Readdata_o=0xDEADBEEF in DONE.
- lb signed at 0x13 with word 0x80FF1234 -> Readdata_o=0xFFFFFF80; lbu at the same address -> 0x00000080; lh signed at 0x12 -> 0xFFFF80FF.
- sb 0x000000AA at 0x21 with word 8 = 0x11223344 -> one read then one write at addr 8 with mem_wdata_o=0x1122AA44, stall_o high 3 cycles.
- sw with mem_ready_i held low 4 cycles -> mem_write_o and mem_wdata_o stable 5 cycles, stall_o high 6 cycles, exactly one write.
- rst_n_i dropped during RMW_RD of an sh -> strobes go 0 asynchronously, no write issued, IDLE after release; the re-presented sh completes correctly.
- With MISALIGN_TRAP_EN: lw at 0x22 -> misalign_o 1 pulse, no strobe, Readdata_o=0. Without it: the same access reads word 8.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_access_ctrl: MEM-stage load/store controller driving a word-only,   |
// | ready-handshaked data memory; sub-word stores use read-modify-write.     |
// | Optional: define MISALIGN_TRAP_EN to trap misaligned half/word accesses. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_access_ctrl #(
    parameter int MEM_WORDS = 256
) (
    input  logic                                           clk_i,
    input  logic                                           rst_n_i,
    input  logic                                           req_i,
    input  logic                                           MemRead_i,
    input  logic                                           MemWrite_i,
    input  logic [1:0]                                     size_i,
    input  logic                                           unsigned_i,
    input  logic [31:0]                                    Address_i,
    input  logic [31:0]                                    Writedata_i,
    output logic [31:0]                                    Readdata_o,
    output logic                                           stall_o,
    output logic                                           misalign_o,
    output logic [((MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1)-1:0] mem_addr_o,
    output logic                                           mem_read_o,
    output logic                                           mem_write_o,
    output logic [31:0]                                    mem_wdata_o,
    input  logic [31:0]                                    mem_rdata_i,
    input  logic                                           mem_ready_i
);

    localparam int         c_aw      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_aw-1:0]   r_addr;
    logic [1:0]        r_size;
    logic [1:0]        r_byte_off;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_start;
    logic              w_trap;
    logic [1:0]        w_size_n;
    logic [1:0]        w_off;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [31:0]       w_load_ext;
    logic [31:0]       w_merged;
    logic              w_unused_addr;

    assign w_start       = req_i & (MemRead_i | MemWrite_i);
    assign w_size_n      = (size_i == 2'b11) ? c_sz_word : size_i;
    assign w_unused_addr = ^Address_i[31:c_aw+2];

    // Byte offset within the word, with alignment forced for half/word accesses.
    always_comb begin
        w_off = 2'b00;
        case (w_size_n)
            c_sz_byte: w_off = Address_i[1:0];
            c_sz_half: w_off = {Address_i[1], 1'b0};
            default:   w_off = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    assign w_misalign = ((w_size_n == c_sz_half) && Address_i[0]) ||
                        ((w_size_n == c_sz_word) && (Address_i[1:0] != 2'b00));
    assign w_trap     = w_start & w_misalign;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) && w_trap;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign w_trap     = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_trap) begin
                        w_state_nxt = S_DONE;
                    end else if (MemWrite_i) begin
                        w_state_nxt = (w_size_n == c_sz_word) ? S_WR : S_RMW_RD;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD:     if (mem_ready_i) w_state_nxt = S_DONE;
            S_WR:     if (mem_ready_i) w_state_nxt = S_DONE;
            S_RMW_RD: if (mem_ready_i) w_state_nxt = S_RMW_WR;
            S_RMW_WR: if (mem_ready_i) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Lane selection and extension of the returned word for loads.
    always_comb begin
        w_lane_byte = mem_rdata_i[7:0];
        case (r_byte_off)
            2'd0: w_lane_byte = mem_rdata_i[7:0];
            2'd1: w_lane_byte = mem_rdata_i[15:8];
            2'd2: w_lane_byte = mem_rdata_i[23:16];
            2'd3: w_lane_byte = mem_rdata_i[31:24];
            default: w_lane_byte = mem_rdata_i[7:0];
        endcase
        w_lane_half = r_byte_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        w_load_ext  = mem_rdata_i;
        case (r_size)
            c_sz_byte: w_load_ext = {{24{~r_unsigned & w_lane_byte[7]}}, w_lane_byte};
            c_sz_half: w_load_ext = {{16{~r_unsigned & w_lane_half[15]}}, w_lane_half};
            default:   w_load_ext = mem_rdata_i;
        endcase
    end

    // Store data is still held right-aligned in r_wdata while the old word is read.
    always_comb begin
        w_merged = mem_rdata_i;
        if (r_size == c_sz_byte) begin
            case (r_byte_off)
                2'd0: w_merged[7:0]   = r_wdata[7:0];
                2'd1: w_merged[15:8]  = r_wdata[7:0];
                2'd2: w_merged[23:16] = r_wdata[7:0];
                2'd3: w_merged[31:24] = r_wdata[7:0];
                default: w_merged = mem_rdata_i;
            endcase
        end else if (r_size == c_sz_half) begin
            if (r_byte_off[1]) begin
                w_merged[31:16] = r_wdata[15:0];
            end else begin
                w_merged[15:0]  = r_wdata[15:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_size     <= c_sz_word;
            r_byte_off <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr     <= Address_i[c_aw+1:2];
                        r_size     <= w_size_n;
                        r_byte_off <= w_off;
                        r_unsigned <= unsigned_i;
                        if (MemWrite_i) begin
                            r_wdata <= Writedata_i;
                        end
                        if (w_trap && !MemWrite_i) begin
                            r_rdata <= '0;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready_i) begin
                        r_rdata <= w_load_ext;
                    end
                end
                S_RMW_RD: begin
                    if (mem_ready_i) begin
                        r_wdata <= w_merged;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode the state register so an asynchronous reset drops them at once.
    assign mem_read_o  = (r_state == S_RD) || (r_state == S_RMW_RD);
    assign mem_write_o = (r_state == S_WR) || (r_state == S_RMW_WR);
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign Readdata_o  = r_rdata;
    assign stall_o     = rst_n_i & w_start & (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_access_ctrl: directed self-checking bench for dmem_access_ctrl.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dmem_access_ctrl;

    logic        clk_i;
    logic        rst_n_i;
    logic        req_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] Address_i;
    logic [31:0] Writedata_i;
    logic [31:0] Readdata_o;
    logic        stall_o;
    logic        misalign_o;
    logic [7:0]  mem_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    logic [31:0] mem [0:255];

    int          checks;
    int          errors;

    int          n_stall;
    int          n_rd;
    int          n_wr;
    int          n_both;
    int          n_mis;
    logic        done_seen;
    logic        unstable;
    logic [7:0]  rd_addr;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rdata_done;

    dmem_access_ctrl #(.MEM_WORDS(256)) u_dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_i       (req_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .Address_i   (Address_i),
        .Writedata_i (Writedata_i),
        .Readdata_o  (Readdata_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .mem_addr_o  (mem_addr_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    assign mem_rdata_i = mem[mem_addr_o];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request, plays the memory (ready low for the first `waits`
    // strobe cycles) and tallies per-cycle observations until stall drops.
    task automatic txn(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       input int waits);
        int          lowcnt;
        logic [31:0] first_wdata;
        lowcnt = 0;
        first_wdata = '0;
        @(posedge clk_i); #1;
        req_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; size_i = sz;
        unsigned_i = uns; Address_i = a; Writedata_i = wd; mem_ready_i = 1'b1;
        n_stall = 0; n_rd = 0; n_wr = 0; n_both = 0; n_mis = 0;
        done_seen = 1'b0; unstable = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rdata_done = '0;
        for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
            @(negedge clk_i);
            if (mem_read_o || mem_write_o) begin
                if (lowcnt < waits) begin
                    mem_ready_i = 1'b0;
                    lowcnt++;
                end else begin
                    mem_ready_i = 1'b1;
                end
            end else begin
                mem_ready_i = 1'b1;
            end
            if (stall_o) n_stall++;
            if (mem_read_o) begin
                n_rd++;
                rd_addr = mem_addr_o;
            end
            if (mem_write_o) begin
                n_wr++;
                if (n_wr == 1) first_wdata = mem_wdata_o;
                else if (mem_wdata_o !== first_wdata || mem_addr_o !== wr_addr) unstable = 1'b1;
                wr_addr = mem_addr_o;
                wr_data = mem_wdata_o;
                if (mem_ready_i) mem[mem_addr_o] = mem_wdata_o;
            end
            if (mem_read_o && mem_write_o) n_both++;
            if (misalign_o) n_mis++;
            if (!stall_o) begin
                done_seen  = 1'b1;
                rdata_done = Readdata_o;
            end
        end
        chk("txn_completes", {31'b0, done_seen}, 32'd1);
        chk("no_strobe_overlap", n_both, 32'd0);
        @(posedge clk_i); #1;
        req_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ready_i = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
        mem[9] = 32'h01020304;

        // Reset with a pending load: everything zero, stall forced low.
        rst_n_i = 1'b0; req_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        size_i = 2'b10; unsigned_i = 1'b0; Address_i = 32'h10; Writedata_i = '0;
        mem_ready_i = 1'b1;
        #12;
        chk("rst_readdata", Readdata_o, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read_o}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write_o}, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_addr", {24'b0, mem_addr_o}, 32'h0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        req_i = 1'b0; MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;

        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        chk("lw_stall", n_stall, 32'd2);
        chk("lw_reads", n_rd, 32'd1);
        chk("lw_addr", {24'b0, rd_addr}, 32'd4);
        chk("lw_writes", n_wr, 32'd0);
        chk("lw_data", rdata_done, 32'hDEADBEEF);

        mem[4] = 32'h80FF1234;
        txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
        chk("lb_signed", rdata_done, 32'hFFFFFF80);
        txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
        chk("lbu", rdata_done, 32'h00000080);
        txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
        chk("lh_signed", rdata_done, 32'hFFFF80FF);
        txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
        chk("lhu", rdata_done, 32'h000080FF);
        txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0);
        chk("lb_lane0", rdata_done, 32'h00000034);
        txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
        chk("lh_lane0_pos", rdata_done, 32'h00001234);

        txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 0);
        chk("sb_stall", n_stall, 32'd3);
        chk("sb_reads", n_rd, 32'd1);
        chk("sb_writes", n_wr, 32'd1);
        chk("sb_waddr", {24'b0, wr_addr}, 32'd8);
        chk("sb_wdata", wr_data, 32'h1122AA44);
        chk("sb_mem", mem[8], 32'h1122AA44);
        chk("sb_readdata_held", rdata_done, 32'h00001234);

        txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 4);
        chk("sw_wait_stall", n_stall, 32'd6);
        chk("sw_wait_strobe_cycles", n_wr, 32'd5);
        chk("sw_wait_stable", {31'b0, unstable}, 32'd0);
        chk("sw_wait_reads", n_rd, 32'd0);
        chk("sw_wait_mem", mem[16], 32'hCAFEF00D);

        // Request with neither read nor write is ignored.
        @(posedge clk_i); #1;
        req_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        @(negedge clk_i);
        chk("noop_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk_i);
        chk("noop_strobes", {30'b0, mem_read_o, mem_write_o}, 32'd0);
        req_i = 1'b0;

        txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h12345678, 0);
        chk("rw_write_wins_reads", n_rd, 32'd0);
        chk("rw_write_wins_mem", mem[17], 32'h12345678);

        txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
        chk("size11_is_word", rdata_done, 32'h80FF1234);

        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h410, 32'h0, 0);
        chk("addr_wrap", {24'b0, rd_addr}, 32'd4);

        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lw_pulse", n_mis, 32'd1);
        chk("mis_lw_reads", n_rd, 32'd0);
        chk("mis_lw_stall", n_stall, 32'd1);
        chk("mis_lw_data", rdata_done, 32'h0);
`else
        chk("mis_lw_pulse", n_mis, 32'd0);
        chk("mis_lw_reads", n_rd, 32'd1);
        chk("mis_lw_addr", {24'b0, rd_addr}, 32'd8);
        chk("mis_lw_data", rdata_done, 32'h1122AA44);
`endif

        txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h25, 32'h00007777, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_sh_writes", n_wr, 32'd0);
        chk("mis_sh_mem", mem[9], 32'h01020304);
`else
        chk("mis_sh_writes", n_wr, 32'd1);
        chk("mis_sh_mem", mem[9], 32'h01027777);
`endif

        // Reset during the read half of a halfword read-modify-write.
        mem[12] = 32'hAABBCCDD;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0; req_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b1;
        size_i = 2'b01; unsigned_i = 1'b0; Address_i = 32'h32; Writedata_i = 32'h5566;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rmw_rd_active", {31'b0, mem_read_o}, 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("midrst_read", {31'b0, mem_read_o}, 32'd0);
        chk("midrst_write", {31'b0, mem_write_o}, 32'd0);
        chk("midrst_stall", {31'b0, stall_o}, 32'd0);
        req_i = 1'b0; MemWrite_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_idle_strobes", {30'b0, mem_read_o, mem_write_o}, 32'd0);
        chk("midrst_mem_untouched", mem[12], 32'hAABBCCDD);
        txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h00005566, 0);
        chk("resh_writes", n_wr, 32'd1);
        chk("resh_stall", n_stall, 32'd3);
        chk("resh_mem", mem[12], 32'h5566CCDD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
